spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI responder (mode 0: CPOL=0, CPHA=0). Counterpart of the team's SPI master.
//  Oversamples the SPI pins on the system clock: shifts a DW-bit word out on miso
//  while shifting a DW-bit word in from mosi. Connects SPI pins to the register/DA-side logic.
//  Words are LSB first by default, matching the master; several words may be sent per cs_n frame.
// PARAMETERS
//  DW          8     word width in bits (>=2)
//  LSB_FIRST   1     1: bit 0 shifted first; 0: bit DW-1 first
//  SYNC_STAGES 2     flip-flop stages on cs_n/sclk/mosi (>=2)
//  DEFAULT_TX  0     word sent when no tx word is buffered (underrun)
// PORTS
//  clk         in   1   system clock; sclk period must be >= 8 clk periods
//  reset       in   1   synchronous, active-high
//  cs_n        in   1   chip select from master, active low, asynchronous to clk
//  sclk        in   1   SPI clock from master, asynchronous to clk
//  mosi        in   1   serial data from master
//  miso        out  1   serial data to master
//  miso_oe     out  1   1 = drive miso pad; 0 = tri-state (cs_n high)
//  tx_data     in   DW  next word to send
//  tx_valid    in   1   tx_data valid
//  tx_ready    out  1   1-entry tx buffer empty; handshake on tx_valid&tx_ready
//  rx_data     out  DW  last complete received word; held until the next one
//  rx_valid    out  1   1-cycle pulse when rx_data updates (no backpressure)
//  tx_underrun out  1   1-cycle pulse when DEFAULT_TX was loaded for lack of a word
//  busy        out  1   1 while in state ACTIVE
// BEHAVIOUR
//  - Sync: cs_n/sclk/mosi pass through SYNC_STAGES FFs (reset to 1/0/0). Edges are
//    detected on the synced copies only. sclk_rise/sclk_fall/cs_fall/cs_rise = 1-clk strobes.
//  - Reset: state IDLE. miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0,
//    tx_underrun=0, busy=0. Buffer, shift registers and bit_cnt cleared.
//    Reset mid-frame aborts the frame; the partial word is lost.
//  - tx buffer: tx_valid&tx_ready -> buffer holds tx_data, tx_ready=0 next clk.
//    A load into the shift register empties the buffer (tx_ready=1 next clk).
//  - LOAD (an internal action, not a state) takes the buffer if full; if empty it takes
//    DEFAULT_TX and pulses tx_underrun. If a handshake and a LOAD fall in the same clk,
//    the LOAD sees an empty buffer (underrun). The new word stays buffered for the next word.
//  - FSM IDLE:  on cs_fall -> ACTIVE. LOAD, bit_cnt=0. miso=first bit of the loaded word
//    and miso_oe=1 on the next clk. sclk edges are ignored while in IDLE.
//  - FSM ACTIVE:
//      sclk_rise: shift synced mosi into the rx shift register (LSB_FIRST order); bit_cnt++.
//        If bit_cnt reaches DW, on the next clk: rx_data=assembled word, rx_valid=1, bit_cnt=0.
//      sclk_fall: if bit_cnt!=0, advance the tx shift register and put the next bit on miso.
//        If bit_cnt==0 after a completed word, LOAD and put the first bit of the new word on miso.
//      cs_rise (takes priority over an sclk edge in the same clk): -> IDLE, miso_oe=0, miso=0,
//        bit_cnt=0. The partial rx word is dropped with no rx_valid. A word already loaded
//        counts as consumed.
//  - Latency: rx_valid <= SYNC_STAGES+2 clks after the last sclk rising edge at the pin.
//  - Only bit_cnt values 0..DW-1 are legal; wrap is through the word-complete path only.
// TESTING
//  T1 reset high 2 clks mid-frame -> all outputs at reset values, busy=0, tx_ready=1.
//  T2 buffer tx 0xA5, master sends 0x3C in one 8-bit frame -> miso bits LSB first
//     1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready back to 1.
//  T3 frame with no buffered word -> miso sends 0x00, one tx_underrun pulse, rx still valid.
//  T4 3 words (0x01,0x80,0xFF) in one cs_n frame, each word buffered during the previous one
//     -> 3 rx_valid pulses in order, miso words match, no underrun.
//  T5 cs_n rises after 5 sclk edges -> no rx_valid, miso_oe=0; next full frame is received correctly.
//  T6 LSB_FIRST=0, DW=16: tx 0x8001 / rx 0x1234 -> miso MSB first, rx_data=0x1234.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder that runs on the system clock.
// cs_n/sclk/mosi are synchronised and edge-detected on clk. A DW-bit word is
// shifted out on miso while a DW-bit word is shifted in from mosi. One word can
// be buffered for transmit, and a frame may carry several consecutive words.
module spi_slave #(
  parameter int              DW          = 8,
  parameter int              LSB_FIRST   = 1,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DW-1:0]   DEFAULT_TX  = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs_n,
  input  logic          sclk,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          tx_underrun,
  output logic          busy
);

  localparam int             CW        = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DW - 1);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [0:0]     ST_IDLE   = 1'b0;
  localparam logic [0:0]     ST_ACTIVE = 1'b1;

  // Bit that goes on the wire first for a freshly loaded word.
  function automatic logic first_bit(input logic [DW-1:0] w);
    if (LSB_FIRST != 0) first_bit = w[0];
    else                first_bit = w[DW-1];
  endfunction

  // Drop the bit just sent so the next one sits in the "first bit" slot.
  function automatic logic [DW-1:0] tx_advance(input logic [DW-1:0] w);
    if (LSB_FIRST != 0) tx_advance = {1'b0, w[DW-1:1]};
    else                tx_advance = {w[DW-2:0], 1'b0};
  endfunction

  // Insert a received bit so that after DW bits the word is in natural order.
  function automatic logic [DW-1:0] rx_insert(input logic [DW-1:0] w, input logic b);
    if (LSB_FIRST != 0) rx_insert = {b, w[DW-1:1]};
    else                rx_insert = {w[DW-2:0], b};
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   cs_prev_r;
  logic                   sclk_prev_r;

  logic                   cs_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;

  logic [0:0]             state_r,       state_nxt_s;
  logic [CW-1:0]          bit_cnt_r,     bit_cnt_nxt_s;
  logic                   word_done_r,   word_done_nxt_s;
  logic [DW-1:0]          tx_sh_r,       tx_sh_nxt_s;
  logic [DW-1:0]          rx_sh_r,       rx_sh_nxt_s;
  logic [DW-1:0]          buf_r,         buf_nxt_s;
  logic                   tx_ready_r,    tx_ready_nxt_s;
  logic                   miso_r,        miso_nxt_s;
  logic                   miso_oe_r,     miso_oe_nxt_s;
  logic [DW-1:0]          rx_data_r,     rx_data_nxt_s;
  logic                   rx_valid_r,    rx_valid_nxt_s;
  logic                   tx_underrun_r, tx_underrun_nxt_s;
  logic                   busy_r,        busy_nxt_s;
  logic                   load_s;
  logic [DW-1:0]          load_word_s;
  logic [DW-1:0]          rx_word_s;
  logic [DW-1:0]          tx_adv_s;

  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_fall_s   = cs_prev_r & ~cs_s;
  assign cs_rise_s   = ~cs_prev_r & cs_s;
  assign sclk_rise_s = ~sclk_prev_r & sclk_s;
  assign sclk_fall_s = sclk_prev_r & ~sclk_s;

  // Bring the asynchronous SPI pins into the clk domain and keep the previous synced values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_prev_r   <= 1'b1;
      sclk_prev_r <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_prev_r   <= cs_s;
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame FSM, shift registers and the one-entry transmit buffer.
  always_comb begin
    state_nxt_s       = state_r;
    bit_cnt_nxt_s     = bit_cnt_r;
    word_done_nxt_s   = word_done_r;
    tx_sh_nxt_s       = tx_sh_r;
    rx_sh_nxt_s       = rx_sh_r;
    buf_nxt_s         = buf_r;
    tx_ready_nxt_s    = tx_ready_r;
    miso_nxt_s        = miso_r;
    miso_oe_nxt_s     = miso_oe_r;
    rx_data_nxt_s     = rx_data_r;
    rx_valid_nxt_s    = 1'b0;
    tx_underrun_nxt_s = 1'b0;
    load_s            = 1'b0;
    rx_word_s         = rx_insert(rx_sh_r, mosi_s);
    tx_adv_s          = tx_advance(tx_sh_r);
    // An empty buffer (tx_ready high) means this load is an underrun.
    load_word_s       = tx_ready_r ? DEFAULT_TX : buf_r;

    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s     = ST_ACTIVE;
          load_s          = 1'b1;
          bit_cnt_nxt_s   = CNT_ZERO;
          word_done_nxt_s = 1'b0;
          miso_oe_nxt_s   = 1'b1;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Deselect wins over any sclk edge seen in the same cycle.
        if (cs_rise_s) begin
          state_nxt_s     = ST_IDLE;
          miso_oe_nxt_s   = 1'b0;
          miso_nxt_s      = 1'b0;
          bit_cnt_nxt_s   = CNT_ZERO;
          word_done_nxt_s = 1'b0;
        end else if (sclk_rise_s) begin
          rx_sh_nxt_s = rx_word_s;
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_nxt_s   = rx_word_s;
            rx_valid_nxt_s  = 1'b1;
            bit_cnt_nxt_s   = CNT_ZERO;
            word_done_nxt_s = 1'b1;
          end else begin
            bit_cnt_nxt_s   = bit_cnt_r + CNT_ONE;
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_r != CNT_ZERO) begin
            tx_sh_nxt_s = tx_adv_s;
            miso_nxt_s  = first_bit(tx_adv_s);
          end else if (word_done_r) begin
            // Falling edge after a completed word starts the next word.
            load_s          = 1'b1;
            word_done_nxt_s = 1'b0;
          end else begin
            word_done_nxt_s = word_done_r;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        miso_oe_nxt_s   = 1'b0;
        miso_nxt_s      = 1'b0;
        bit_cnt_nxt_s   = CNT_ZERO;
        word_done_nxt_s = 1'b0;
      end
    endcase

    if (load_s) begin
      tx_sh_nxt_s       = load_word_s;
      miso_nxt_s        = first_bit(load_word_s);
      tx_underrun_nxt_s = tx_ready_r;
      tx_ready_nxt_s    = 1'b1;
    end else begin
      tx_sh_nxt_s       = tx_sh_nxt_s;
    end

    // A handshake in the same cycle as a load stays buffered for the next word.
    if (tx_valid && tx_ready_r) begin
      buf_nxt_s      = tx_data;
      tx_ready_nxt_s = 1'b0;
    end else begin
      buf_nxt_s      = buf_nxt_s;
    end

    busy_nxt_s = (state_nxt_s == ST_ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= CNT_ZERO;
      word_done_r   <= 1'b0;
      tx_sh_r       <= {DW{1'b0}};
      rx_sh_r       <= {DW{1'b0}};
      buf_r         <= {DW{1'b0}};
      tx_ready_r    <= 1'b1;
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
      rx_data_r     <= {DW{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      word_done_r   <= word_done_nxt_s;
      tx_sh_r       <= tx_sh_nxt_s;
      rx_sh_r       <= rx_sh_nxt_s;
      buf_r         <= buf_nxt_s;
      tx_ready_r    <= tx_ready_nxt_s;
      miso_r        <= miso_nxt_s;
      miso_oe_r     <= miso_oe_nxt_s;
      rx_data_r     <= rx_data_nxt_s;
      rx_valid_r    <= rx_valid_nxt_s;
      tx_underrun_r <= tx_underrun_nxt_s;
      busy_r        <= busy_nxt_s;
    end
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign tx_ready    = tx_ready_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: a mode-0 bus master plus a word-level reference
// model (which words go out on miso, which come back on rx_data, how many
// underruns). One 8-bit LSB-first instance and one 16-bit MSB-first instance.
module tb_spi_slave;

  localparam int HALF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cs_n, sclk, mosi, sel, tx_valid;
  logic [15:0] tx_data;

  logic        cs8, cs16, txv8, txv16;
  logic        miso8, oe8, rdy8, rxv8, ur8, busy8;
  logic [7:0]  rxd8;
  logic        miso16, oe16, rdy16, rxv16, ur16, busy16;
  logic [15:0] rxd16;

  assign cs8   = sel ? 1'b1 : cs_n;
  assign cs16  = sel ? cs_n : 1'b1;
  assign txv8  = tx_valid & ~sel;
  assign txv16 = tx_valid & sel;

  logic miso_sel, oe_sel, rdy_sel, busy_sel;
  logic [15:0] rxd_sel;
  assign miso_sel = sel ? miso16 : miso8;
  assign oe_sel   = sel ? oe16   : oe8;
  assign rdy_sel  = sel ? rdy16  : rdy8;
  assign busy_sel = sel ? busy16 : busy8;
  assign rxd_sel  = sel ? rxd16  : {8'h00, rxd8};

  spi_slave u_dut8 (
    .clk(clk), .reset(reset), .cs_n(cs8), .sclk(sclk), .mosi(mosi),
    .miso(miso8), .miso_oe(oe8), .tx_data(tx_data[7:0]), .tx_valid(txv8),
    .tx_ready(rdy8), .rx_data(rxd8), .rx_valid(rxv8), .tx_underrun(ur8), .busy(busy8)
  );

  spi_slave #(.DW(16), .LSB_FIRST(0)) u_dut16 (
    .clk(clk), .reset(reset), .cs_n(cs16), .sclk(sclk), .mosi(mosi),
    .miso(miso16), .miso_oe(oe16), .tx_data(tx_data), .tx_valid(txv16),
    .tx_ready(rdy16), .rx_data(rxd16), .rx_valid(rxv16), .tx_underrun(ur16), .busy(busy16)
  );

  int tests = 0;
  int fails = 0;

  // Received words and underrun pulses, collected from both instances.
  logic [15:0] rx_q[$];
  int          ur_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rxv8)  rx_q.push_back({8'h00, rxd8});
    if (rxv16) rx_q.push_back(rxd16);
    if (ur8)   ur_cnt++;
    if (ur16)  ur_cnt++;
  end

  logic [15:0] mw  [4];
  logic [15:0] got [4];
  logic [15:0] txw [4];
  logic [15:0] etx [4];
  bit          use_tx [4];
  int          words_started;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word on tx_valid and hold it until the handshake happens.
  task automatic push_tx(input logic [15:0] w);
    int t;
    t = 0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    while (!rdy_sel && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("tx_handshake", rdy_sel, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: nw words of dw bits; cut>0 deselects after cut rising edges.
  // The final sclk fall coincides with cs_n rising.
  task automatic run_frame(input int nw, input int dw, input bit lsb, input int cut);
    int total;
    total = (cut > 0) ? cut : nw * dw;
    words_started = 0;
    for (int w = 0; w < 4; w++) got[w] = 16'h0000;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int n = 0; n < total; n++) begin
      int w, i, b;
      w = n / dw;
      i = n % dw;
      b = lsb ? i : dw - 1 - i;
      mosi = mw[w][b];
      repeat (HALF) @(negedge clk);
      got[w][b] = miso_sel;
      if (i == 0) words_started = w + 1;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (n == total - 1) cs_n = 1'b1;
    end
    mosi = 1'b0;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // Buffer word k only after word k-1 has been loaded.
  task automatic feed(input int nw, input logic [15:0] mask);
    for (int k = 1; k < nw; k++) begin
      if (use_tx[k]) begin
        int t;
        t = 0;
        while (words_started < k && t < 5000) begin
          @(negedge clk);
          t++;
        end
        check("feed_wait", (words_started >= k), 1);
        push_tx(txw[k] & mask);
      end
    end
  endtask

  // Full frame against the model: each word goes out as the buffered word or 0.
  task automatic do_frame(input string tag, input int nw, input int dw, input bit lsb);
    int exp_ur, rx_base, ur_base;
    logic [15:0] mask;
    mask   = (dw == 16) ? 16'hFFFF : 16'h00FF;
    exp_ur = 0;
    for (int w = 0; w < nw; w++) begin
      mw[w]  = mw[w] & mask;
      etx[w] = use_tx[w] ? (txw[w] & mask) : 16'h0000;
      if (!use_tx[w]) exp_ur++;
    end
    rx_base = rx_q.size();
    ur_base = ur_cnt;
    if (use_tx[0]) push_tx(txw[0] & mask);
    fork
      run_frame(nw, dw, lsb, 0);
      feed(nw, mask);
    join
    for (int w = 0; w < nw; w++) begin
      check({tag, "_miso"}, got[w], etx[w]);
      check({tag, "_rx"}, (rx_q.size() > rx_base + w) ? rx_q[rx_base + w] : 16'hxxxx, mw[w]);
    end
    check({tag, "_rx_count"}, rx_q.size() - rx_base, nw);
    check({tag, "_underruns"}, ur_cnt - ur_base, exp_ur);
    check({tag, "_tx_ready"}, rdy_sel, 1);
    check({tag, "_oe_idle"}, oe_sel, 0);
  endtask

  initial begin
    int rx_base, ur_base, nw;
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    sel = 1'b0; tx_valid = 1'b0; tx_data = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_miso", miso8, 0);
    check("rst_oe", oe8, 0);
    check("rst_ready", rdy8, 1);
    check("rst_rxdata", rxd8, 0);
    check("rst_rxvalid", rxv8, 0);
    check("rst_underrun", ur8, 0);
    check("rst_busy", busy8, 0);

    // T1: reset mid-frame.
    rx_base = rx_q.size();
    ur_base = ur_cnt;
    push_tx(16'h005A);
    cs_n = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    sclk = 1'b1; repeat (HALF) @(negedge clk);
    sclk = 1'b0; repeat (HALF) @(negedge clk);
    sclk = 1'b1; repeat (HALF) @(negedge clk);
    push_tx(16'h00C3);
    check("t1_busy_pre", busy8, 1);
    check("t1_oe_pre", oe8, 1);
    check("t1_ready_pre", rdy8, 0);
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t1_busy", busy8, 0);
    check("t1_ready", rdy8, 1);
    check("t1_oe", oe8, 0);
    check("t1_miso", miso8, 0);
    check("t1_rxdata", rxd8, 0);
    repeat (2 * HALF) @(negedge clk);
    check("t1_busy_after", busy8, 0);
    check("t1_no_rx", rx_q.size() - rx_base, 0);
    check("t1_no_underrun", ur_cnt - ur_base, 0);

    // T2: 0xA5 out, 0x3C in.
    mw[0] = 16'h003C; txw[0] = 16'h00A5; use_tx[0] = 1'b1;
    do_frame("t2", 1, 8, 1'b1);

    // T3: nothing buffered -> 0x00 and one underrun.
    mw[0] = 16'($urandom); use_tx[0] = 1'b0;
    do_frame("t3", 1, 8, 1'b1);

    // T4: three words in one frame, each buffered during the previous one.
    mw[0] = 16'h0001; mw[1] = 16'h0080; mw[2] = 16'h00FF;
    for (int w = 0; w < 3; w++) begin
      txw[w] = 16'($urandom);
      use_tx[w] = 1'b1;
    end
    do_frame("t4", 3, 8, 1'b1);

    // T5: deselect after 5 rising edges; loaded word counts as consumed.
    rx_base = rx_q.size();
    ur_base = ur_cnt;
    mw[0] = 16'($urandom) & 16'h00FF;
    push_tx(16'($urandom) & 16'h00FF);
    run_frame(1, 8, 1'b1, 5);
    check("t5_no_rx", rx_q.size() - rx_base, 0);
    check("t5_oe", oe8, 0);
    check("t5_busy", busy8, 0);
    check("t5_ready", rdy8, 1);
    check("t5_no_underrun", ur_cnt - ur_base, 0);
    mw[0] = 16'($urandom); txw[0] = 16'($urandom); use_tx[0] = 1'b1;
    do_frame("t5_next", 1, 8, 1'b1);

    // Randomised frames with a random mix of buffered words and underruns.
    for (int r = 0; r < 6; r++) begin
      nw = 1 + int'($urandom_range(2, 0));
      for (int w = 0; w < 4; w++) begin
        mw[w]     = 16'($urandom);
        txw[w]    = 16'($urandom);
        use_tx[w] = 1'($urandom_range(1, 0));
      end
      do_frame("rnd8", nw, 8, 1'b1);
    end

    // T6: 16-bit MSB-first instance.
    sel = 1'b1;
    @(negedge clk);
    mw[0] = 16'h1234; txw[0] = 16'h8001; use_tx[0] = 1'b1;
    do_frame("t6", 1, 16, 1'b0);
    for (int w = 0; w < 4; w++) begin
      mw[w]     = 16'($urandom);
      txw[w]    = 16'($urandom);
      use_tx[w] = 1'($urandom_range(1, 0));
    end
    do_frame("rnd16", 2, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
